matrix_stream_loader: RTL and testbench
=======================================

Name: matrix_stream_loader

Overview:
- Upstream stage of the array-transpose block in dotinator.
- Collects a ROW_SIZE x COL_SIZE matrix, delivered one element per beat in row-major order over a valid/ready stream, into a register buffer.
- Presents the complete matrix as an unpacked array with a valid/ready handshake, held stable for the transpose stage and downstream dot-product logic.
- Detects framing errors using an in_last marker.

Parameters:
- ROW_SIZE, 4, number of rows in the matrix.
- COL_SIZE, 4, number of columns in the matrix.
- DATA_WIDTH, 32, bit width of each element.

Ports:
- clk  input  1  single clock; all logic is rising-edge triggered.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data and in_last are valid this cycle.
- in_ready  output  1  loader can accept an element this cycle.
- in_data  input  DATA_WIDTH  element value, row-major order.
- in_last  input  1  marks the final element (index ROW_SIZE*COL_SIZE-1) of a frame.
- out_valid  output  1  out_array holds a complete matrix.
- out_ready  input  1  consumer accepts the matrix.
- out_array  output  DATA_WIDTH x [ROW_SIZE][COL_SIZE]  matrix buffer, same shape as the transpose input.
- elem_count  output  $clog2(ROW_SIZE*COL_SIZE+1)  number of elements accepted in the current frame.
- frame_err  output  1  sticky framing-error flag.
- err_clear  input  1  synchronous clear of frame_err.

Behaviour:
- Reset (async assert, sync release): state FILL; row, col and elem_count = 0; out_valid = 0; frame_err = 0; all out_array entries = 0; in_ready = 1 on the first cycle after release.
- States:
  - FILL: in_ready = 1, out_valid = 0.
  - FULL: in_ready = 0, out_valid = 1.
- in_ready is a pure function of state, with no combinational path from out_ready.
- Accept occurs when in_valid & in_ready:
  - Write in_data to out_array[row][col].
  - col increments; at COL_SIZE-1, col wraps to 0 and row increments.
  - elem_count increments.
- Final element (elem_count == ROW_SIZE*COL_SIZE-1 at accept):
  - Next cycle: state FULL, out_valid = 1, row, col and elem_count = 0.
  - Latency from final accept to out_valid is 1 cycle.
  - If in_last = 0 on this beat, set frame_err; the frame still completes.
- Early in_last (in_last = 1 on any earlier index):
  - The element is written.
  - frame_err is set.
  - row, col and elem_count reset to 0; state stays FILL.
  - The partial frame is discarded and out_valid is not raised.
- FULL:
  - out_array is held bit-stable and out_valid stays 1 until out_valid & out_ready.
  - On that handshake, the next cycle is FILL with in_ready = 1. Minimum gap between frames: 1 bubble cycle.
- out_array is not cleared after the handshake; entries are overwritten by the next frame.
- While in FILL, out_array entries are not guaranteed coherent (partial frame visible). Consumers sample only when out_valid = 1.
- out_ready is ignored in FILL; in_valid is ignored in FULL, with no write and no error.
- frame_err:
  - Set by the error conditions above; err_clear = 1 clears it next cycle.
  - If set and clear coincide in the same cycle, set wins.
- Upstream rules: in_data and in_last must be held while in_valid = 1 and in_ready = 0. The loader never drops an accepted element.
- Reset asserted mid-frame or in FULL: immediate return to reset values; the partial or held matrix is lost.
- Degenerate 1x1 configuration: every accepted element completes a frame; in_last is expected on every beat.

Test Plan:
- Basic fill (4x4x32): send 16 beats, values 0x00..0x0F, in_last on beat 15, out_ready = 0.
  - Required: out_valid rises 1 cycle after beat 15; out_array[r][c] = 4r+c; in_ready = 0; frame_err = 0.
  - Then pulse out_ready for 1 cycle: in_ready = 1 on the next cycle.
- Backpressure hold: keep out_ready = 0 for 20 cycles in FULL while driving in_valid = 1 with 0xDEADBEEF.
  - Required: out_array unchanged; elem_count = 0; no writes.
- Throttled input: random in_valid gaps during a fill with values 0x100+i.
  - Required: elem_count tracks accepts; a single out_valid pulse; out_array[3][3] = 0x10F.
- Early in_last: in_last on beat 5 (index 5), then a full correct 16-beat frame.
  - Required: frame_err = 1 after beat 5; elem_count returns to 0; the second frame completes with correct values.
  - Then err_clear = 1: frame_err = 0 next cycle.
- Missing in_last: 16 beats with in_last = 0.
  - Required: out_valid = 1 and frame_err = 1.
  - err_clear coinciding with a new error leaves frame_err = 1.
- Reset mid-frame: assert rst_n = 0 after 7 beats.
  - Required: immediately out_valid = 0, elem_count = 0, out_array all 0, frame_err = 0.
  - After release: in_ready = 1, and a full frame loads correctly.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Collects a ROW_SIZE x COL_SIZE matrix from a row-major element stream into a
// register buffer and presents it whole, with in_last framing-error detection.
module matrix_stream_loader #(
  parameter int ROW_SIZE   = 4,
  parameter int COL_SIZE   = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [DATA_WIDTH-1:0]                   in_data,
  input  logic                                    in_last,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   out_array [ROW_SIZE][COL_SIZE],
  output logic [$clog2(ROW_SIZE*COL_SIZE+1)-1:0]  elem_count,
  output logic                                    frame_err,
  input  logic                                    err_clear
);

  localparam int N   = ROW_SIZE * COL_SIZE;
  localparam int CW  = $clog2(N + 1);
  localparam int RW  = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int CLW = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;
  localparam logic [CW-1:0]  LAST_IDX = CW'(N - 1);
  localparam logic [CLW-1:0] COL_LAST = CLW'(COL_SIZE - 1);

  typedef enum logic {FILL, FULL} state_t;

  state_t         state, state_nxt;
  logic [RW-1:0]  row;
  logic [CLW-1:0] col;
  logic           accept;
  logic           is_final;
  logic           done;
  logic           early;
  logic           err_set;

  // Handshake outputs depend on state only, so out_ready never reaches in_ready.
  assign in_ready  = (state == FILL);
  assign out_valid = (state == FULL);

  assign accept   = in_valid & in_ready;
  assign is_final = (elem_count == LAST_IDX);
  assign done     = accept & is_final;
  assign early    = accept & in_last & ~is_final;
  assign err_set  = early | (done & ~in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (done)      state_nxt = FULL;
      FULL:    if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Both a completed frame and an early in_last restart indexing at element 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      elem_count <= '0;
    end else if (done || early) begin
      row        <= '0;
      col        <= '0;
      elem_count <= '0;
    end else if (accept) begin
      elem_count <= elem_count + CW'(1);
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + RW'(1);
      end else begin
        col <= col + CLW'(1);
      end
    end
  end

  // A new error takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= err_set | (frame_err & ~err_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROW_SIZE; r++)
        for (int c = 0; c < COL_SIZE; c++)
          out_array[r][c] <= '0;
    end else if (accept) begin
      out_array[row][col] <= in_data;
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader: a frame-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_matrix_stream_loader;

  localparam int R = 4;
  localparam int C = 4;
  localparam int N = R * C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_array [R][C];
  logic [4:0]  elem_count;
  logic        frame_err;
  logic        err_clear;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  logic ov_prev = 1'b0;

  matrix_stream_loader #(.ROW_SIZE(R), .COL_SIZE(C), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_array(out_array), .elem_count(elem_count),
    .frame_err(frame_err), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of element indices; idx maps to [idx/C][idx%C].
  logic        m_full;
  int          m_cnt;
  logic        m_err;
  logic [31:0] m_arr [R][C];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full <= 1'b0;
      m_cnt  <= 0;
      m_err  <= 1'b0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          m_arr[r][c] <= '0;
    end else if (!m_full && in_valid) begin
      m_arr[m_cnt / C][m_cnt % C] <= in_data;
      if (m_cnt == N - 1) begin
        m_full <= 1'b1;
        m_cnt  <= 0;
        m_err  <= !in_last ? 1'b1 : (m_err && !err_clear);
      end else if (in_last) begin
        m_cnt <= 0;
        m_err <= 1'b1;
      end else begin
        m_cnt <= m_cnt + 1;
        m_err <= m_err && !err_clear;
      end
    end else begin
      if (m_full && out_ready) m_full <= 1'b0;
      m_err <= m_err && !err_clear;
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_full);
    chk("in_ready", in_ready, !m_full);
    chk("elem_count", elem_count, m_cnt);
    chk("frame_err", frame_err, m_err);
    if (m_full)
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          chk("out_array", out_array[r][c], m_arr[r][c]);
    if (out_valid && !ov_prev) pulses++;
    ov_prev <= out_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && guard < 100) begin
      idle(1);
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 1, 0);
    idle(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; err_clear = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_elem_count", elem_count, 0);
    chk("rst_frame_err", frame_err, 0);

    // Basic fill
    for (int i = 0; i < N; i++) send(i, i == N - 1);
    chk("basic_out_valid", out_valid, 1);
    chk("basic_in_ready", in_ready, 0);
    chk("basic_frame_err", frame_err, 0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        chk("basic_elem", out_array[r][c], 4 * r + c);

    // Backpressure hold with ignored input traffic
    in_valid = 1'b1; in_data = 32'hDEADBEEF;
    idle(20);
    in_valid = 1'b0;
    chk("hold_count", elem_count, 0);
    chk("hold_00", out_array[0][0], 32'h0);
    chk("hold_33", out_array[3][3], 32'hF);
    chk("hold_valid", out_valid, 1);
    handshake();
    chk("after_hs_in_ready", in_ready, 1);

    // Throttled input
    p0 = pulses;
    for (int i = 0; i < N; i++) begin
      idle($urandom_range(0, 2));
      send(32'h100 + i, i == N - 1);
    end
    idle(2);
    chk("thr_pulses", pulses - p0, 1);
    chk("thr_33", out_array[3][3], 32'h10F);
    chk("thr_00", out_array[0][0], 32'h100);
    handshake();

    // Early in_last at index 5, then a clean frame
    for (int i = 0; i < 6; i++) send(32'h200 + i, i == 5);
    chk("early_err", frame_err, 1);
    chk("early_count", elem_count, 0);
    chk("early_no_valid", out_valid, 0);
    for (int i = 0; i < N; i++) send(32'h300 + i, i == N - 1);
    chk("early2_valid", out_valid, 1);
    chk("early2_21", out_array[2][1], 32'h309);
    chk("early2_33", out_array[3][3], 32'h30F);
    handshake();
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    chk("clear_err", frame_err, 0);

    // Missing in_last
    for (int i = 0; i < N; i++) send(32'h400 + i, 1'b0);
    chk("miss_valid", out_valid, 1);
    chk("miss_err", frame_err, 1);
    chk("miss_12", out_array[1][2], 32'h406);
    handshake();
    err_clear = 1'b1;
    send(32'h55, 1'b1);
    err_clear = 1'b0;
    chk("set_wins", frame_err, 1);
    chk("set_wins_count", elem_count, 0);

    // Reset mid-frame
    for (int i = 0; i < 7; i++) send(32'h500 + i, 1'b0);
    chk("pre_rst_count", elem_count, 7);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_count", elem_count, 0);
    chk("mrst_err", frame_err, 0);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        chk("mrst_arr", out_array[r][c], 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    chk("mrst_in_ready", in_ready, 1);
    for (int i = 0; i < N; i++) send(32'h600 + i, i == N - 1);
    chk("mrst_frame_valid", out_valid, 1);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        chk("mrst_frame_elem", out_array[r][c], 32'h600 + 4 * r + c);
    handshake();
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
